// File: rtl/ex_wb_stage_if.sv
// ex_wb_stage_if
//   Bundles the execute-to-writeback stage signals.
//   in_*  : one instruction from the ALU stage; in_valid qualifies all of them.
//   out_* : registered writeback, PC redirect, flush and flag outputs.
//   dbg_* : FSM state (0 = RUN, 1 = FLUSH) and the flush counter, for checkers.
//   Modports: master drives in_* (upstream / bench), slave is the stage itself.
interface ex_wb_stage_if #(
  parameter int WIDTH   = 32,
  parameter int RD_BITS = 6
);
  logic               in_valid;
  logic [WIDTH-1:0]   in_result;
  logic               in_zero;
  logic               in_neg;
  logic [WIDTH-1:0]   in_mem_data;
  logic               in_ctrl_memtoreg;
  logic               in_ctrl_regwrite;
  logic               in_ctrl_setflags;
  logic [1:0]         in_ctrl_branch;
  logic [WIDTH-1:0]   in_target;
  logic [RD_BITS-1:0] in_rd;

  logic               out_reg_we;
  logic [RD_BITS-1:0] out_reg_addr;
  logic [WIDTH-1:0]   out_reg_data;
  logic               out_pc_sel;
  logic [WIDTH-1:0]   out_pc_target;
  logic               out_flush;
  logic               out_flag_z;
  logic               out_flag_n;

  logic               dbg_state;
  logic [2:0]         dbg_flush_cnt;

  modport master (
    output in_valid, in_result, in_zero, in_neg, in_mem_data,
           in_ctrl_memtoreg, in_ctrl_regwrite, in_ctrl_setflags,
           in_ctrl_branch, in_target, in_rd,
    input  out_reg_we, out_reg_addr, out_reg_data, out_pc_sel,
           out_pc_target, out_flush, out_flag_z, out_flag_n,
           dbg_state, dbg_flush_cnt
  );

  modport slave (
    input  in_valid, in_result, in_zero, in_neg, in_mem_data,
           in_ctrl_memtoreg, in_ctrl_regwrite, in_ctrl_setflags,
           in_ctrl_branch, in_target, in_rd,
    output out_reg_we, out_reg_addr, out_reg_data, out_pc_sel,
           out_pc_target, out_flush, out_flag_z, out_flag_n,
           dbg_state, dbg_flush_cnt
  );
endinterface

// File: rtl/ex_wb_stage.sv
// ex_wb_stage
//   Execute-to-writeback stage. Registers the ALU result, selects ALU or
//   memory data for register writeback, owns the architectural Z/N flags,
//   resolves BRZ/BRN/jump against those flags and drives a PC redirect
//   followed by a FLUSH_CYCLES-long flush shadow.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - ex_wb_stage_if.slave (in_* instruction, out_* results, dbg_* state)
// Configuration:
//   WB_R0_PROTECT_EN - when defined, writes to register 0 are suppressed.
// Handshake: there is no backpressure. An instruction is consumed on the
//   rising edge where in_valid=1 and the FSM is in RUN; at any other edge the
//   in_* signals are ignored entirely (no write, no flag update, no branch).
module ex_wb_stage #(
  parameter int WIDTH        = 32,
  parameter int RD_BITS      = 6,
  parameter int FLUSH_CYCLES = 2
) (
  input logic          clk,
  input logic          rst,
  ex_wb_stage_if.slave bus
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;

  logic               accept;
  logic               taken;
  logic               we_d;
  logic [WIDTH-1:0]   wb_data;

  logic               reg_we_q;
  logic [RD_BITS-1:0] reg_addr_q;
  logic [WIDTH-1:0]   reg_data_q;
  logic               pc_sel_q;
  logic [WIDTH-1:0]   pc_target_q;
  logic               flag_z_q;
  logic               flag_n_q;

  assign accept  = bus.in_valid && (state_q == RUN);
  assign wb_data = bus.in_ctrl_memtoreg ? bus.in_mem_data : bus.in_result;

  // Branch condition reads the flag register as it stands before this
  // edge, so a setter in the previous cycle is already visible here.
  always_comb begin
    taken = 1'b0;
    case (bus.in_ctrl_branch)
      2'b01:   taken = flag_z_q;
      2'b10:   taken = flag_n_q;
      2'b11:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

`ifdef WB_R0_PROTECT_EN
  assign we_d = bus.in_ctrl_regwrite && (bus.in_rd != '0);
`else
  assign we_d = bus.in_ctrl_regwrite;
`endif

  // Next-state: a taken branch opens the shadow; the counter then counts the
  // remaining shadow cycles down to 0 before returning to RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (accept && taken) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LAST;
        end
      end
      FLUSH: begin
        if (cnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      pc_sel_q    <= 1'b0;
      pc_target_q <= '0;
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
    end else begin
      reg_we_q <= 1'b0;
      pc_sel_q <= 1'b0;
      if (accept) begin
        reg_we_q   <= we_d;
        reg_addr_q <= bus.in_rd;
        reg_data_q <= wb_data;
        if (bus.in_ctrl_setflags) begin
          flag_z_q <= bus.in_zero;
          flag_n_q <= bus.in_neg;
        end
        if (taken) begin
          pc_sel_q    <= 1'b1;
          pc_target_q <= bus.in_target;
        end
      end
    end
  end

  assign bus.out_reg_we    = reg_we_q;
  assign bus.out_reg_addr  = reg_addr_q;
  assign bus.out_reg_data  = reg_data_q;
  assign bus.out_pc_sel    = pc_sel_q;
  assign bus.out_pc_target = pc_target_q;
  assign bus.out_flush     = (state_q == FLUSH);
  assign bus.out_flag_z    = flag_z_q;
  assign bus.out_flag_n    = flag_n_q;
  assign bus.dbg_state     = state_q;
  assign bus.dbg_flush_cnt = cnt_q;

endmodule

// File: tb/tb_ex_wb_stage.sv
// tb_ex_wb_stage
//   Bench for ex_wb_stage: directed scenarios followed by random traffic.
//   The driver pushes the expected post-edge outputs into a queue; a monitor
//   pops one entry per cycle, 1 ns after each rising edge, and compares.
module tb_ex_wb_stage;

  localparam int WIDTH        = 32;
  localparam int RD_BITS      = 6;
  localparam int FLUSH_CYCLES = 2;

  typedef struct packed {
    logic               we;
    logic [RD_BITS-1:0] addr;
    logic [WIDTH-1:0]   data;
    logic               pc_sel;
    logic [WIDTH-1:0]   target;
    logic               flush;
    logic               z;
    logic               n;
  } exp_t;

  localparam int W = $bits(exp_t);

  typedef struct {
    logic               valid;
    logic [WIDTH-1:0]   result;
    logic               zero;
    logic               neg;
    logic [WIDTH-1:0]   mem;
    logic               memtoreg;
    logic               regwrite;
    logic               setflags;
    logic [1:0]         br;
    logic [WIDTH-1:0]   target;
    logic [RD_BITS-1:0] rd;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_wb_stage_if #(.WIDTH(WIDTH), .RD_BITS(RD_BITS)) bus ();

  ex_wb_stage #(
    .WIDTH(WIDTH), .RD_BITS(RD_BITS), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: architectural flags, held writeback values and the
  // number of flush cycles still to be shown (0 = not flushing).
  logic               m_z, m_n;
  logic [RD_BITS-1:0] m_addr;
  logic [WIDTH-1:0]   m_data;
  logic [WIDTH-1:0]   m_target;
  int                 m_shadow;

  function automatic txn_t mk(input logic valid, input logic [WIDTH-1:0] result,
                              input logic zero, input logic neg,
                              input logic [WIDTH-1:0] mem, input logic memtoreg,
                              input logic regwrite, input logic setflags,
                              input logic [1:0] br, input logic [WIDTH-1:0] target,
                              input logic [RD_BITS-1:0] rd);
    txn_t t;
    t.valid = valid; t.result = result; t.zero = zero; t.neg = neg;
    t.mem = mem; t.memtoreg = memtoreg; t.regwrite = regwrite;
    t.setflags = setflags; t.br = br; t.target = target; t.rd = rd;
    return t;
  endfunction

  function automatic txn_t idle();
    return mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, '0);
  endfunction

  task automatic model_reset();
    m_z = 1'b0; m_n = 1'b0;
    m_addr = '0; m_data = '0; m_target = '0;
    m_shadow = 0;
    exp_q.delete();
  endtask

  function automatic exp_t model_step(input txn_t t);
    exp_t e;
    logic flushing, acc, tk;
    flushing = (m_shadow > 0);
    if (flushing) m_shadow = m_shadow - 1;
    acc = t.valid && !flushing;
    e.we = 1'b0;
    e.pc_sel = 1'b0;
    if (acc) begin
      tk = (t.br == 2'b11) || (t.br == 2'b01 && m_z) || (t.br == 2'b10 && m_n);
`ifdef WB_R0_PROTECT_EN
      e.we = t.regwrite && (t.rd != 0);
`else
      e.we = t.regwrite;
`endif
      m_addr = t.rd;
      m_data = t.memtoreg ? t.mem : t.result;
      if (t.setflags) begin
        m_z = t.zero;
        m_n = t.neg;
      end
      if (tk) begin
        e.pc_sel = 1'b1;
        m_target = t.target;
        m_shadow = FLUSH_CYCLES;
      end
    end
    e.addr   = m_addr;
    e.data   = m_data;
    e.target = m_target;
    e.flush  = (m_shadow > 0);
    e.z      = m_z;
    e.n      = m_n;
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input txn_t t);
    exp_t e;
    @(negedge clk);
    bus.in_valid         = t.valid;
    bus.in_result        = t.result;
    bus.in_zero          = t.zero;
    bus.in_neg           = t.neg;
    bus.in_mem_data      = t.mem;
    bus.in_ctrl_memtoreg = t.memtoreg;
    bus.in_ctrl_regwrite = t.regwrite;
    bus.in_ctrl_setflags = t.setflags;
    bus.in_ctrl_branch   = t.br;
    bus.in_target        = t.target;
    bus.in_rd            = t.rd;
    e = model_step(t);
    exp_q.push_back(W'(e));
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0b required=%0b", name, act, req);
  endtask

  // Outputs must already be zero right after rst rises, before any edge.
  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_flush"}, bus.out_flush, 1'b0);
    check_bit({tag, "_pc_sel"}, bus.out_pc_sel, 1'b0);
    check_bit({tag, "_we"}, bus.out_reg_we, 1'b0);
    check_bit({tag, "_flags"}, bus.out_flag_z | bus.out_flag_n, 1'b0);
    check_bit({tag, "_regs_zero"},
              (bus.out_reg_addr == '0) && (bus.out_reg_data == '0) &&
              (bus.out_pc_target == '0), 1'b1);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs(tag);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  exp_t mon_a;
  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      mon_e = exp_t'(exp_q.pop_front());
      mon_a.we     = bus.out_reg_we;
      mon_a.addr   = bus.out_reg_addr;
      mon_a.data   = bus.out_reg_data;
      mon_a.pc_sel = bus.out_pc_sel;
      mon_a.target = bus.out_pc_target;
      mon_a.flush  = bus.out_flush;
      mon_a.z      = bus.out_flag_z;
      mon_a.n      = bus.out_flag_n;
      n_checks++;
      if (mon_a.we === mon_e.we && mon_a.addr === mon_e.addr &&
          mon_a.data === mon_e.data && mon_a.pc_sel === mon_e.pc_sel &&
          (!mon_e.pc_sel || mon_a.target === mon_e.target) &&
          mon_a.flush === mon_e.flush && mon_a.z === mon_e.z &&
          mon_a.n === mon_e.n) begin
        n_pass++;
      end else begin
        $display("FAIL cycle_out t=%0t: actual we=%0b addr=%0d data=%h pc_sel=%0b tgt=%h flush=%0b z=%0b n=%0b required we=%0b addr=%0d data=%h pc_sel=%0b tgt=%h flush=%0b z=%0b n=%0b",
                 $time, mon_a.we, mon_a.addr, mon_a.data, mon_a.pc_sel, mon_a.target,
                 mon_a.flush, mon_a.z, mon_a.n, mon_e.we, mon_e.addr, mon_e.data,
                 mon_e.pc_sel, mon_e.target, mon_e.flush, mon_e.z, mon_e.n);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    txn_t t;
    bus.in_valid = 1'b0; bus.in_result = '0; bus.in_zero = 1'b0; bus.in_neg = 1'b0;
    bus.in_mem_data = '0; bus.in_ctrl_memtoreg = 1'b0; bus.in_ctrl_regwrite = 1'b0;
    bus.in_ctrl_setflags = 1'b0; bus.in_ctrl_branch = 2'b00; bus.in_target = '0;
    bus.in_rd = '0;
    model_reset();

    // Power-on reset raised between edges.
    #2 rst = 1'b1;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ALU write, then memory write to the same register.
    drive(mk(1, 32'h0000_0005, 0, 0, 32'h1234_5678, 0, 1, 0, 2'b00, 32'h0, 6'd3));
    drive(mk(1, 32'h0000_0005, 0, 0, 32'hDEAD_BEEF, 1, 1, 0, 2'b00, 32'h0, 6'd3));
    drive(idle());

    // Zero-setter then BRZ (taken), shadow, then idle.
    drive(mk(1, 32'h0, 1, 0, 32'h0, 0, 1, 1, 2'b00, 32'h0, 6'd4));
    drive(mk(1, 32'h0, 0, 0, 32'h0, 0, 0, 0, 2'b01, 32'h40, 6'd0));
    repeat (3) drive(idle());

    // Non-zero setter then BRZ (not taken).
    drive(mk(1, 32'h7, 0, 0, 32'h0, 0, 1, 1, 2'b00, 32'h0, 6'd5));
    drive(mk(1, 32'h0, 0, 0, 32'h0, 0, 0, 0, 2'b01, 32'h40, 6'd0));
    drive(idle());

    // Shadow squash: N=1 setter, jump, two squashed (one a BRN), then accepted.
    drive(mk(1, 32'h8000_0000, 0, 1, 32'h0, 0, 0, 1, 2'b00, 32'h0, 6'd0));
    drive(mk(1, 32'h11, 0, 0, 32'h0, 0, 0, 0, 2'b11, 32'h100, 6'd0));
    drive(mk(1, 32'h22, 1, 0, 32'h0, 0, 1, 1, 2'b00, 32'h0, 6'd7));
    drive(mk(1, 32'h33, 0, 0, 32'h0, 0, 1, 0, 2'b10, 32'h200, 6'd8));
    drive(mk(1, 32'h44, 0, 0, 32'h0, 0, 1, 0, 2'b00, 32'h0, 6'd9));
    drive(idle());

    // Reset during the first flush cycle, then a normal instruction.
    drive(mk(1, 32'h55, 0, 0, 32'h0, 0, 0, 0, 2'b11, 32'h300, 6'd0));
    async_reset("mid_flush");
    drive(mk(1, 32'h66, 0, 0, 32'h0, 0, 1, 0, 2'b00, 32'h0, 6'd10));
    drive(idle());

    // Register 0 write.
    drive(mk(1, 32'h77, 0, 0, 32'h0, 0, 1, 0, 2'b00, 32'h0, 6'd0));
    drive(idle());

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      t.valid    = ($urandom_range(0, 3) != 0);
      t.result   = $urandom;
      t.zero     = $urandom_range(0, 1);
      t.neg      = $urandom_range(0, 1);
      t.mem      = $urandom;
      t.memtoreg = $urandom_range(0, 1);
      t.regwrite = $urandom_range(0, 1);
      t.setflags = $urandom_range(0, 1);
      t.br       = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      t.target   = $urandom;
      t.rd       = RD_BITS'($urandom_range(0, 63));
      drive(t);
      if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
    end
    drive(idle());

    // Let the last expectation be consumed, then confirm the queue drained.
    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: actual=%0d entries left required=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
